// File: rtl/alu_word_seq_65ce02.sv
// Drives the external 8-bit ALU low byte then high byte to build 16-bit INW/DEW/ASW/ROW/ADW results.
// Latency: done 3 rdy-edges after the accepting edge; rdy=0 freezes every register, done included.
module alu_word_seq_65ce02 (
  input  logic        clk,
  input  logic        reset,
  input  logic        rdy,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [15:0] a_in,
  input  logic [15:0] b_in,
  input  logic        c_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        n_out,
  output logic        z_out,
  output logic        c_out,
  output logic        v_out,
  output logic [3:0]  alu_op,
  output logic        alu_right,
  output logic        alu_arith,
  output logic        alu_bcd,
  output logic [7:0]  alu_ai,
  output logic [7:0]  alu_bi,
  output logic        alu_ci,
  output logic        alu_rdy,
  input  logic [7:0]  alu_out,
  input  logic        alu_co,
  input  logic        alu_v
);

  localparam logic [2:0] OP_INW = 3'd0;
  localparam logic [2:0] OP_DEW = 3'd1;
  localparam logic [2:0] OP_ASW = 3'd2;
  localparam logic [2:0] OP_ROW = 3'd3;
  localparam logic [2:0] OP_ADW = 3'd4;

  typedef enum logic [1:0] {IDLE, LO, HI, FIN} state_t;

  state_t      state;
  logic [2:0]  op_q;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic        c_q;
  logic [7:0]  result_lo;
  logic [15:0] word;
  logic [3:0]  op_code;
  logic        ci_lo;
  logic [15:0] bi_word;

  assign busy      = (state != IDLE);
  assign alu_right = 1'b0;
  assign alu_arith = 1'b0;
  assign alu_bcd   = 1'b0;
  assign alu_rdy   = rdy;
  assign word      = {alu_out, result_lo};

  // op_q only ever holds a legal op, so the default arm is ADW.
  always_comb begin
    op_code = 4'b0011;
    ci_lo   = 1'b0;
    bi_word = 16'h0000;
    case (op_q)
      OP_INW: ci_lo = 1'b1;
      OP_DEW: op_code = 4'b0111;
      OP_ASW: op_code = 4'b1011;
      OP_ROW: begin
        op_code = 4'b1011;
        ci_lo   = c_q;
      end
      default: begin
        bi_word = b_q;
        ci_lo   = c_q;
      end
    endcase
  end

  // High byte takes its carry straight from the ALU's registered low-byte carry.
  always_comb begin
    alu_op = 4'b1111;
    alu_ai = 8'h00;
    alu_bi = 8'h00;
    alu_ci = 1'b0;
    case (state)
      LO: begin
        alu_op = op_code;
        alu_ai = a_q[7:0];
        alu_bi = bi_word[7:0];
        alu_ci = ci_lo;
      end
      HI: begin
        alu_op = op_code;
        alu_ai = a_q[15:8];
        alu_bi = bi_word[15:8];
        alu_ci = alu_co;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      op_q      <= OP_INW;
      a_q       <= 16'h0000;
      b_q       <= 16'h0000;
      c_q       <= 1'b0;
      result_lo <= 8'h00;
      result    <= 16'h0000;
      n_out     <= 1'b0;
      z_out     <= 1'b0;
      c_out     <= 1'b0;
      v_out     <= 1'b0;
      done      <= 1'b0;
    end else if (rdy) begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && (op <= OP_ADW)) begin
            op_q  <= op;
            a_q   <= a_in;
            b_q   <= b_in;
            c_q   <= c_in;
            state <= LO;
          end
        end
        LO: state <= HI;
        HI: begin
          result_lo <= alu_out;
          state     <= FIN;
        end
        default: begin
          result <= word;
          n_out  <= word[15];
          z_out  <= (word == 16'h0000);
          c_out  <= alu_co;
          v_out  <= alu_v;
          done   <= 1'b1;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_word_seq_65ce02.sv
// Scoreboard bench: word-level reference model plus a behavioural 8-bit ALU in the loop.
module tb_alu_word_seq_65ce02;

  logic        clk = 1'b0;
  logic        reset, rdy, start, c_in;
  logic [2:0]  op;
  logic [15:0] a_in, b_in;
  logic        busy, done, n_out, z_out, c_out, v_out;
  logic [15:0] result;
  logic [3:0]  alu_op;
  logic        alu_right, alu_arith, alu_bcd, alu_ci, alu_rdy;
  logic [7:0]  alu_ai, alu_bi;
  logic [7:0]  alu_out = 8'h00;
  logic        alu_co = 1'b0;
  logic        alu_v = 1'b0;

  typedef struct {
    logic [15:0] r;
    logic        n, z, c, v;
    int          k;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   rdy_edges = 0;
  bit   rand_rdy = 0;

  alu_word_seq_65ce02 dut (
    .clk(clk), .reset(reset), .rdy(rdy), .start(start), .op(op),
    .a_in(a_in), .b_in(b_in), .c_in(c_in), .busy(busy), .done(done),
    .result(result), .n_out(n_out), .z_out(z_out), .c_out(c_out), .v_out(v_out),
    .alu_op(alu_op), .alu_right(alu_right), .alu_arith(alu_arith), .alu_bcd(alu_bcd),
    .alu_ai(alu_ai), .alu_bi(alu_bi), .alu_ci(alu_ci), .alu_rdy(alu_rdy),
    .alu_out(alu_out), .alu_co(alu_co), .alu_v(alu_v)
  );

  always #5 clk = ~clk;

  // Environment ALU: returns {v, co, out}, registered with one cycle of latency.
  function automatic logic [9:0] alu_fn(input logic [3:0] o, input logic [7:0] ai, bi, input logic ci);
    logic [7:0] y;
    logic [8:0] s;
    case (o)
      4'b0011: y = bi;
      4'b0111: y = ~bi;
      4'b1011: y = ai;
      default: y = 8'h00;
    endcase
    s = {1'b0, ai} + {1'b0, y} + {8'd0, ci};
    return {(ai[7] == y[7]) && (s[7] != ai[7]), s[8], s[7:0]};
  endfunction

  always @(posedge clk) if (alu_rdy) {alu_v, alu_co, alu_out} <= alu_fn(alu_op, alu_ai, alu_bi, alu_ci);

  always @(posedge clk) if (rdy) rdy_edges <= rdy_edges + 1;

  always @(posedge clk) begin
    #1;
    if (rand_rdy) rdy = ($urandom_range(0, 3) != 0);
  end

  function automatic exp_t ref_model(input logic [2:0] o, input logic [15:0] a, b, input logic c);
    exp_t e;
    logic [16:0] s;
    e.k = 0;
    case (o)
      3'd0: begin e.r = a + 16'd1; e.c = (a == 16'hFFFF); e.v = (a == 16'h7FFF); end
      3'd1: begin e.r = a - 16'd1; e.c = (a != 16'h0000); e.v = (a == 16'h8000); end
      3'd2: begin e.r = a << 1; e.c = a[15]; e.v = a[15] ^ a[14]; end
      3'd3: begin e.r = {a[14:0], c}; e.c = a[15]; e.v = a[15] ^ a[14]; end
      default: begin
        s = {1'b0, a} + {1'b0, b} + {16'd0, c};
        e.r = s[15:0];
        e.c = s[16];
        e.v = (a[15] == b[15]) && (s[15] != a[15]);
      end
    endcase
    e.n = e.r[15];
    e.z = (e.r == 16'h0000);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // A done cycle ends at the first rdy=1 edge, so it is consumed exactly once.
  always @(negedge clk) begin
    if (!reset && done && rdy) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got result %h with nothing outstanding", result);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("result", {16'd0, result}, {16'd0, e.r});
        chk("flags_nzcv", {28'd0, n_out, z_out, c_out, v_out}, {28'd0, e.n, e.z, e.c, e.v});
        chk("latency", rdy_edges, e.k + 3);
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [15:0] a, b, input logic c,
                       input bit push, input bit keep);
    exp_t e;
    int t;
    start = 1'b1; op = o; a_in = a; b_in = b; c_in = c;
    t = 0;
    @(negedge clk);
    while (busy || !rdy) begin
      t++;
      if (t > 200) begin
        n_cmp++;
        n_bad++;
        $display("FAIL accept_timeout: got busy=%b after %0d cycles required idle", busy, t);
        start = 1'b0;
        return;
      end
      @(negedge clk);
    end
    e = ref_model(o, a, b, c);
    e.k = rdy_edges + 1;
    if (push) sbq.push_back(e);
    @(posedge clk);
    #1;
    if (!keep) start = 1'b0;
  endtask

  logic [2:0]  d_op [7] = '{3'd0, 3'd1, 3'd1, 3'd3, 3'd2, 3'd4, 3'd4};
  logic [15:0] d_a  [7] = '{16'h00FF, 16'h0000, 16'h0100, 16'h8001, 16'h4000, 16'h7FFF, 16'hFFFF};
  logic [15:0] d_b  [7] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 16'h0001};
  logic        d_c  [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    reset = 1'b1; rdy = 1'b1; start = 1'b0; op = 3'd0;
    a_in = 16'h0000; b_in = 16'h0000; c_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy_done", {30'd0, busy, done}, 32'd0);
    chk("reset_result", {16'd0, result}, 32'd0);
    chk("reset_flags", {28'd0, n_out, z_out, c_out, v_out}, 32'd0);
    chk("reset_alu_drive", {15'd0, alu_op, alu_ai, alu_bi, alu_ci}, {15'd0, 4'b1111, 8'h00, 8'h00, 1'b0});
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) issue(d_op[i], d_a[i], d_b[i], d_c[i], 1'b1, 1'b0);

    // Back-to-back: second op is accepted in the first op's done cycle.
    issue(3'd4, 16'h1234, 16'h4321, 1'b1, 1'b1, 1'b1);
    issue(3'd0, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0);

    // Stall three cycles while the high byte is on the ALU inputs.
    issue(3'd4, 16'h12F0, 16'h0130, 1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    rdy = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_hi_drive", {15'd0, alu_op, alu_ai, alu_bi, alu_ci}, {15'd0, 4'b0011, 8'h12, 8'h01, 1'b1});
      @(posedge clk);
      #1;
    end
    rdy = 1'b1;

    // Reset in FIN abandons the operation.
    issue(3'd2, 16'h4000, 16'h0000, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("finreset_busy_done", {30'd0, busy, done}, 32'd0);
    chk("finreset_alu_drive", {15'd0, alu_op, alu_ai, alu_bi, alu_ci}, {15'd0, 4'b1111, 8'h00, 8'h00, 1'b0});
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("finreset_result", {16'd0, result}, 32'd0);

    // Reserved op must never be accepted.
    start = 1'b1; op = 3'd6; a_in = 16'h5555;
    repeat (5) begin
      @(negedge clk);
      chk("reserved_busy_done", {30'd0, busy, done}, 32'd0);
    end
    @(posedge clk);
    #1;
    start = 1'b0;

    rand_rdy = 1;
    for (int i = 0; i < 80; i++)
      issue(3'($urandom_range(0, 4)), 16'($urandom), 16'($urandom), 1'($urandom),
            1'b1, (i != 79) && ($urandom_range(0, 1) == 1));
    start = 1'b0;
    rand_rdy = 0;
    @(posedge clk);
    #1;
    rdy = 1'b1;
    for (int t = 0; t < 50 && sbq.size() != 0; t++) @(posedge clk);
    #1;
    chk("outstanding_after_drain", sbq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_word_seq_65ce02.md
Name: alu_word_seq_65ce02

Overview:
Sequencer for the 65CE02 16-bit word operations (INW, DEW, ASW, ROW, plus a 16-bit add ADW). It sits directly upstream of the 8-bit ALU, alu_65ce02. It drives the ALU inputs for the low byte and then the high byte, chaining the ALU carry-out between them. It collects the two registered ALU result bytes and presents a 16-bit result with N/Z/C/V flags to the core.

Parameters:
none

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
rdy  input  1  core RDY; when low, all state holds; forwarded to the ALU as alu_rdy
start  input  1  request; sampled only in IDLE with rdy=1
op  input  3  000 INW, 001 DEW, 010 ASW, 011 ROW, 100 ADW; 101-111 reserved
a_in  input  16  word operand
b_in  input  16  second operand (ADW only)
c_in  input  1  carry flag in (ROW, ADW)
busy  output  1  high in states LO, HI, FIN
done  output  1  one-cycle pulse; result and flags are valid from this cycle on
result  output  16  word result, held until the next done
n_out  output  1  result[15]
z_out  output  1  result==16'h0000
c_out  output  1  carry out of the high byte
v_out  output  1  alu_v sampled on the high byte
alu_op  output  4  ALU op
alu_right  output  1  always 0
alu_arith  output  1  always 0
alu_bcd  output  1  always 0
alu_ai  output  8  ALU AI
alu_bi  output  8  ALU BI
alu_ci  output  1  ALU CI
alu_rdy  output  1  equal to rdy
alu_out  input  8  ALU OUT (registered in the ALU, 1-cycle latency)
alu_co  input  1  ALU CO
alu_v  input  1  ALU V

Behaviour:
- States: IDLE, LO, HI, FIN. No transition occurs while rdy=0; every register holds.
- IDLE: if start=1, rdy=1 and op<=100, latch op, a_in, b_in and c_in, then go to LO. Reserved ops are ignored: stay in IDLE, no busy, no done.
- LO: drive the low byte from the latched operands, then go to HI.
- HI: capture alu_out into result_lo (an internal register). Drive the high byte with alu_ci = alu_co, which is the carry from the low byte. Go to FIN.
- FIN: capture result = {alu_out, result_lo}, c_out = alu_co, v_out = alu_v, and n_out/z_out from the 16-bit value. Assert done for the following cycle, then go to IDLE.
- Latency: start accepted at edge E, done high in the cycle after edge E+3. A new start is accepted in the same cycle that done is high.
- Per-op ALU drive (low byte / high byte). The low and high bytes use the same ALU op.
  - INW: alu_op=0011, BI=00, low CI=1.
  - DEW: alu_op=0111, BI=00 (ALU computes AI+FF+CI), low CI=0.
  - ASW: alu_op=1011 (AI+AI), BI=don't-care, low CI=0.
  - ROW: alu_op=1011, low CI=latched c_in.
  - ADW: alu_op=0011, BI=b_lo then b_hi, low CI=latched c_in.
- Outside LO/HI: alu_op=1111, alu_ai=alu_bi=00, alu_ci=0.
- c_out/v_out are always reported; the core decides which flags the opcode updates. INW/DEW leave C untouched at the core level.
- Reset, asynchronous and possibly mid-operation:
  - state=IDLE; busy=0, done=0, result=0000, n_out=z_out=c_out=v_out=0.
  - alu_op=1111, alu_ai=alu_bi=00, alu_ci=0.
  - The operation in flight is abandoned and no done is emitted.
- Once asserted, done may be stretched only by rdy=0 stalls; it clears after the first cycle with rdy=1.

Test Plan:
- INW: a_in=00FF -> result=0100, z=0, n=0, c=0; done exactly 4 edges after start.
- DEW a_in=0000 -> result=FFFF, n=1, c=0. DEW a_in=0100 -> result=00FF, c=1.
- ROW a_in=8001, c_in=1 -> result=0003, c=1. ASW a_in=4000 -> result=8000, n=1, c=0.
- ADW a_in=7FFF, b_in=0001, c_in=0 -> result=8000, v=1, n=1. ADW FFFF+0001 -> result=0000, z=1, c=1.
- rdy low for 3 cycles while in HI -> alu_ai/op/ci are held and the final result is unchanged; done is delayed by 3 cycles. Reset asserted in FIN -> no done, result=0000. Reserved op 110 -> no busy.
- Back-to-back: start held high through done -> second op starts in the done cycle; results are correct for both.
